instr_exec: RTL

// - PDP-8 execute stage; consumer end of the decode interface.
// - Drives PC_value/stall toward the decoder and consumes base_addr, pdp_mem_opcode and pdp_op7_opcode.
// - Holds AC/L and executes memory-reference ops (AND TAD ISZ DCA JMS JMP) via a memory port.
// - Executes group-1/2 operate (op7) ops in place; sits between decode and data memory.

---
 rtl/instr_exec.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_exec.sv
// PDP-8 execute stage: consumes decoded mem/op7 structs and runs them against AC/L and a data memory port.
// Build option: define PDP8_AUTOINDEX_EN to auto-increment pointers fetched indirectly through 0010-0017.

`ifndef START_ADDRESS
`define START_ADDRESS 12'o0200
`endif

package instr_exec_pkg;

  typedef struct packed {
    logic       AND;
    logic       TAD;
    logic       ISZ;
    logic       DCA;
    logic       JMS;
    logic       JMP;
    logic [8:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

endpackage

module instr_exec
  import instr_exec_pkg::*;
#(
  parameter int unsigned DECODE_LAT = 3,
  parameter logic [11:0] START_PC   = `START_ADDRESS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     base_addr,
  input  pdp_mem_opcode_s pdp_mem_opcode,
  input  pdp_op7_opcode_s pdp_op7_opcode,
  input  logic [11:0]     switch_reg,
  input  logic [11:0]     exec_rd_data,
  output logic [11:0]     PC_value,
  output logic            stall,
  output logic            exec_rd_req,
  output logic [11:0]     exec_rd_addr,
  output logic            exec_wr_req,
  output logic [11:0]     exec_wr_addr,
  output logic [11:0]     exec_wr_data,
  output logic [11:0]     ac_out,
  output logic            link_out,
  output logic            halted
);

  localparam int unsigned WW = 12;
  localparam int unsigned CW = (DECODE_LAT > 1) ? $clog2(DECODE_LAT) : 1;

  typedef enum logic [3:0] {
    LOAD, FETCH, SAMPLE, EA, IND_RD, IND_WAIT, AI_WR,
    OP_RD, OP_WAIT, OP_WR, PCUPD, HALT
  } state_e;

  state_e          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [WW-1:0]   pc_q, pc_n, ac_q, ac_n, ea_q, ea_n;
  logic            link_q, link_n, skip_q, skip_n, halted_q, halted_n, stall_q, stall_n;
  pdp_mem_opcode_s mem_q, mem_n;
  logic            rd_req_q, rd_req_n, wr_req_q, wr_req_n;
  logic [WW-1:0]   rd_addr_q, rd_addr_n, wr_addr_q, wr_addr_n, wr_data_q, wr_data_n;

  logic            dispatch;
  logic [WW-1:0]   tgt, ea_calc, inc;
  logic [WW:0]     sum;
  logic [WW+1:0]   op7_res;
  logic            mem_any;
  logic            unused_nop;

  assign unused_nop = pdp_op7_opcode.NOP;
  assign mem_any    = pdp_mem_opcode.AND | pdp_mem_opcode.TAD | pdp_mem_opcode.ISZ |
                      pdp_mem_opcode.DCA | pdp_mem_opcode.JMS | pdp_mem_opcode.JMP;
  assign ea_calc    = {mem_q.mem_inst_addr[7] ? pc_q[11:7] : 5'd0, mem_q.mem_inst_addr[6:0]};

  // Operate instruction: returns {link, ac, skip}; skips test the pre-instruction AC/L.
  function automatic logic [WW+1:0] op7_exec(input pdp_op7_opcode_s o, input logic [WW-1:0] a_in,
                                             input logic l_in, input logic [WW-1:0] sw);
    logic [WW-1:0] a;
    logic          lk, c, sk;
    logic [WW:0]   v;
    sk = o.SKP | (o.SNL & l_in) | (o.SZL & ~l_in) | (o.SZA & (a_in == '0)) |
         (o.SNA & (a_in != '0)) | (o.SMA & a_in[11]) | (o.SPA & ~a_in[11]);
    a  = a_in;
    lk = l_in;
    if (o.CLA1 | o.CLA2 | o.CLA_CLL) a = '0;
    if (o.CLL | o.CLA_CLL) lk = 1'b0;
    if (o.CMA) a = ~a;
    if (o.CML) lk = ~lk;
    if (o.CIA) a = WW'(~a + WW'(1));
    if (o.IAC) begin
      {c, a} = {1'b0, a} + (WW+1)'(1);
      lk = lk ^ c;
    end
    v = {lk, a};
    if (o.RAL) v = {v[WW-1:0], v[WW]};
    if (o.RTL) v = {v[WW-2:0], v[WW:WW-1]};
    if (o.RAR) v = {v[0], v[WW:1]};
    if (o.RTR) v = {v[1:0], v[WW:2]};
    lk = v[WW];
    a  = v[WW-1:0];
    if (o.OSR) a = a | sw;
    return {lk, a, sk};
  endfunction

  // State and datapath registers; reset drops any pending strobe at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      pc_q      <= '0;
      ac_q      <= '0;
      ea_q      <= '0;
      link_q    <= 1'b0;
      skip_q    <= 1'b0;
      halted_q  <= 1'b0;
      stall_q   <= 1'b1;
      mem_q     <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      pc_q      <= pc_n;
      ac_q      <= ac_n;
      ea_q      <= ea_n;
      link_q    <= link_n;
      skip_q    <= skip_n;
      halted_q  <= halted_n;
      stall_q   <= stall_n;
      mem_q     <= mem_n;
      rd_req_q  <= rd_req_n;
      rd_addr_q <= rd_addr_n;
      wr_req_q  <= wr_req_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

  // Next-state, datapath and memory-strobe logic.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    pc_n      = pc_q;
    ac_n      = ac_q;
    ea_n      = ea_q;
    link_n    = link_q;
    skip_n    = skip_q;
    halted_n  = halted_q;
    mem_n     = mem_q;
    rd_req_n  = 1'b0;
    rd_addr_n = rd_addr_q;
    wr_req_n  = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    dispatch  = 1'b0;
    tgt       = '0;
    sum       = '0;
    inc       = '0;
    op7_res   = '0;

    case (state_q)
      LOAD: begin
        pc_n    = $isunknown(base_addr) ? START_PC : base_addr;
        cnt_n   = '0;
        state_n = FETCH;
      end
      FETCH: begin
        if (cnt_q == CW'(DECODE_LAT - 1)) begin
          cnt_n   = '0;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        mem_n = pdp_mem_opcode;
        if (mem_any) begin
          state_n = EA;
        end else if (pdp_op7_opcode.HLT) begin
          halted_n = 1'b1;
          state_n  = HALT;
        end else begin
          op7_res = op7_exec(pdp_op7_opcode, ac_q, link_q, switch_reg);
          {link_n, ac_n, skip_n} = op7_res;
          state_n = PCUPD;
        end
      end
      EA: begin
        if (mem_q.mem_inst_addr[8]) begin
          ea_n      = ea_calc;
          rd_req_n  = 1'b1;
          rd_addr_n = ea_calc;
          state_n   = IND_RD;
        end else begin
          dispatch = 1'b1;
          tgt      = ea_calc;
        end
      end
      IND_RD: state_n = IND_WAIT;
      IND_WAIT: begin
`ifdef PDP8_AUTOINDEX_EN
        if (ea_q[11:3] == 9'd1) begin
          inc       = exec_rd_data + WW'(1);
          ea_n      = inc;
          wr_req_n  = 1'b1;
          wr_addr_n = ea_q;
          wr_data_n = inc;
          state_n   = AI_WR;
        end else begin
          dispatch = 1'b1;
          tgt      = exec_rd_data;
        end
`else
        dispatch = 1'b1;
        tgt      = exec_rd_data;
`endif
      end
      AI_WR: begin
        dispatch = 1'b1;
        tgt      = ea_q;
      end
      OP_RD: state_n = OP_WAIT;
      OP_WAIT: begin
        if (mem_q.ISZ) begin
          inc       = exec_rd_data + WW'(1);
          wr_req_n  = 1'b1;
          wr_addr_n = ea_q;
          wr_data_n = inc;
          skip_n    = (inc == '0);
          state_n   = OP_WR;
        end else begin
          if (mem_q.AND) begin
            ac_n = ac_q & exec_rd_data;
          end else begin
            sum    = {1'b0, ac_q} + {1'b0, exec_rd_data};
            ac_n   = sum[WW-1:0];
            link_n = link_q ^ sum[WW];
          end
          pc_n    = pc_q + WW'(1);
          state_n = FETCH;
        end
      end
      OP_WR: begin
        pc_n    = mem_q.JMS ? ea_q + WW'(1) : pc_q + WW'(1) + WW'(skip_q);
        state_n = FETCH;
      end
      PCUPD: begin
        pc_n    = pc_q + WW'(1) + WW'(skip_q);
        state_n = FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = LOAD;
    endcase

    // Common launch of a memory-reference op once its final EA is known.
    if (dispatch) begin
      ea_n   = tgt;
      skip_n = 1'b0;
      if (mem_q.JMP) begin
        pc_n    = tgt;
        state_n = FETCH;
      end else if (mem_q.JMS) begin
        wr_req_n  = 1'b1;
        wr_addr_n = tgt;
        wr_data_n = pc_q + WW'(1);
        state_n   = OP_WR;
      end else if (mem_q.DCA) begin
        wr_req_n  = 1'b1;
        wr_addr_n = tgt;
        wr_data_n = ac_q;
        ac_n      = '0;
        state_n   = OP_WR;
      end else begin
        rd_req_n  = 1'b1;
        rd_addr_n = tgt;
        state_n   = OP_RD;
      end
    end

    stall_n = (state_n != FETCH);
  end

  assign PC_value     = pc_q;
  assign stall        = stall_q;
  assign exec_rd_req  = rd_req_q;
  assign exec_rd_addr = rd_addr_q;
  assign exec_wr_req  = wr_req_q;
  assign exec_wr_addr = wr_addr_q;
  assign exec_wr_data = wr_data_q;
  assign ac_out       = ac_q;
  assign link_out     = link_q;
  assign halted       = halted_q;

endmodule
